fetch_stage: RTL and testbench

Instruction fetch stage of the single-issue core: owns the program counter, issues one instruction-memory request at a time over a req/gnt/rvalid bus, and presents the fetched word to decode/controller as a held, valid instruction. It sits directly upstream of the controller. Its `inst_valid_o` is the controller's `inst_valid_i`. It consumes the controller's `retire_o`, `target_valid_o`, `pc_mux_sel_o` and `exc_pc_o` to advance or redirect the PC.

---
 rtl/riscv_defines.sv | 28 ++
 rtl/pc_target_mux.sv | 36 +++
 rtl/fetch_stage.sv | 127 ++++++++++++
 tb/tb_fetch_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv_defines
// Shared core definitions: address width, PC redirect source encodings,
// canonical NOP word and a word-alignment helper.
// Revision: 1.0
// ----------------------------------------------------------------------------
package riscv_defines;

  localparam int RISCV_ADDR_WIDTH = 32;

  // Redirect source select driven by the controller
  localparam logic [1:0] PC_BRANCH_JUMP = 2'd0;
  localparam logic [1:0] PC_EPC         = 2'd1;
  localparam logic [1:0] PC_EXCEPTION   = 2'd2;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Instructions are word aligned; drop the two low address bits
  function automatic logic [RISCV_ADDR_WIDTH-1:0] align_word(
    input logic [RISCV_ADDR_WIDTH-1:0] addr
  );
    return {addr[RISCV_ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_target_mux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pc_target_mux
// Combinational redirect-target select (branch/jump, mret EPC, exception
// vector) with forced word alignment.
// Revision: 1.0
// ----------------------------------------------------------------------------
module pc_target_mux
  import riscv_defines::*;
#(
  parameter logic [RISCV_ADDR_WIDTH-1:0] MTVEC_BASE = 32'h0000_0000
) (
  input  logic [1:0]                  pc_mux_sel_i,
  input  logic [RISCV_ADDR_WIDTH-1:0] branch_target_i,
  input  logic [RISCV_ADDR_WIDTH-1:0] epc_i,
  input  logic [RISCV_ADDR_WIDTH-1:0] exc_pc_i,
  output logic [RISCV_ADDR_WIDTH-1:0] target_o
);

  logic [RISCV_ADDR_WIDTH-1:0] w_target_raw;

  // Pick the redirect source; unused encodings fall back to the ALU target
  always_comb begin
    w_target_raw = branch_target_i;
    case (pc_mux_sel_i)
      PC_BRANCH_JUMP: w_target_raw = branch_target_i;
      PC_EPC:         w_target_raw = epc_i;
      PC_EXCEPTION:   w_target_raw = MTVEC_BASE + exc_pc_i;
      default:        w_target_raw = branch_target_i;
    endcase
  end

  assign target_o = align_word(w_target_raw);

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_stage
// Owns the PC, issues one instruction-memory request at a time over the
// req/gnt/rvalid bus and holds the fetched word for decode until the
// controller retires or redirects it.
// Revision: 1.0
// ----------------------------------------------------------------------------
module fetch_stage
  import riscv_defines::*;
#(
  parameter logic [RISCV_ADDR_WIDTH-1:0] BOOT_ADDR  = 32'h0000_0080,
  parameter logic [RISCV_ADDR_WIDTH-1:0] MTVEC_BASE = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        instr_req_o,
  output logic [RISCV_ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                        instr_gnt_i,
  input  logic                        instr_rvalid_i,
  input  logic [31:0]                 instr_rdata_i,
  output logic                        inst_valid_o,
  output logic [31:0]                 instr_o,
  output logic [RISCV_ADDR_WIDTH-1:0] pc_o,
  input  logic                        retire_i,
  input  logic                        target_valid_i,
  input  logic [1:0]                  pc_mux_sel_i,
  input  logic [RISCV_ADDR_WIDTH-1:0] branch_target_i,
  input  logic [RISCV_ADDR_WIDTH-1:0] epc_i,
  input  logic [RISCV_ADDR_WIDTH-1:0] exc_pc_i
);

  localparam logic [1:0] ST_REQ         = 2'd0;
  localparam logic [1:0] ST_WAIT_RVALID = 2'd1;
  localparam logic [1:0] ST_VALID       = 2'd2;

  logic [1:0]                  r_state;
  logic [1:0]                  w_state_next;
  logic [RISCV_ADDR_WIDTH-1:0] r_pc;
  logic [RISCV_ADDR_WIDTH-1:0] w_target;
  logic [31:0]                 r_instr;
  logic [RISCV_ADDR_WIDTH-1:0] r_pc_o;
  logic                        r_inst_valid;

  // Events that matter only in their owning state
  logic w_capture;
  logic w_redirect;
  logic w_advance;

  assign w_capture  = (r_state == ST_WAIT_RVALID) && instr_rvalid_i;
  assign w_redirect = (r_state == ST_VALID) && target_valid_i;
  assign w_advance  = (r_state == ST_VALID) && retire_i && !target_valid_i;

  pc_target_mux #(
    .MTVEC_BASE (MTVEC_BASE)
  ) u_pc_target_mux (
    .pc_mux_sel_i    (pc_mux_sel_i),
    .branch_target_i (branch_target_i),
    .epc_i           (epc_i),
    .exc_pc_i        (exc_pc_i),
    .target_o        (w_target)
  );

  // State register; reset aborts any in-flight transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_REQ;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_REQ: begin
        if (instr_gnt_i) w_state_next = ST_WAIT_RVALID;
      end
      ST_WAIT_RVALID: begin
        if (instr_rvalid_i) w_state_next = ST_VALID;
      end
      ST_VALID: begin
        if (target_valid_i || retire_i) w_state_next = ST_REQ;
      end
      default: w_state_next = ST_REQ;
    endcase
  end

  // Bus outputs decoded from state and PC
  always_comb begin
    instr_req_o  = (r_state == ST_REQ);
    instr_addr_o = r_pc;
  end

  // PC update: redirect takes priority over sequential advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= BOOT_ADDR;
    end else if (w_redirect) begin
      r_pc <= w_target;
    end else if (w_advance) begin
      r_pc <= r_pc + RISCV_ADDR_WIDTH'(4);
    end
  end

  // Held instruction for decode: captured on rvalid, dropped on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr      <= NOP_INSTR;
      r_pc_o       <= BOOT_ADDR;
      r_inst_valid <= 1'b0;
    end else if (w_capture) begin
      r_instr      <= instr_rdata_i;
      r_pc_o       <= r_pc;
      r_inst_valid <= 1'b1;
    end else if (w_redirect || w_advance) begin
      r_inst_valid <= 1'b0;
    end
  end

  assign inst_valid_o = r_inst_valid;
  assign instr_o      = r_instr;
  assign pc_o         = r_pc_o;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch_stage
// Directed self-checking bench for fetch_stage.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        inst_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        retire_i;
  logic        target_valid_i;
  logic [1:0]  pc_mux_sel_i;
  logic [31:0] branch_target_i;
  logic [31:0] epc_i;
  logic [31:0] exc_pc_i;

  int n_cmp;
  int n_err;

  fetch_stage #(
    .BOOT_ADDR  (32'h0000_0080),
    .MTVEC_BASE (32'h0000_0100)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instr_req_o     (instr_req_o),
    .instr_addr_o    (instr_addr_o),
    .instr_gnt_i     (instr_gnt_i),
    .instr_rvalid_i  (instr_rvalid_i),
    .instr_rdata_i   (instr_rdata_i),
    .inst_valid_o    (inst_valid_o),
    .instr_o         (instr_o),
    .pc_o            (pc_o),
    .retire_i        (retire_i),
    .target_valid_i  (target_valid_i),
    .pc_mux_sel_i    (pc_mux_sel_i),
    .branch_target_i (branch_target_i),
    .epc_i           (epc_i),
    .exc_pc_i        (exc_pc_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // From REQ: grant immediately, return data one cycle later
  task automatic fetch(input logic [31:0] data);
    instr_gnt_i = 1'b1;
    cycle();
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = data;
    cycle();
    instr_rvalid_i = 1'b0;
  endtask

  // From VALID: one-cycle redirect pulse
  task automatic redirect(input logic [1:0] sel);
    target_valid_i = 1'b1;
    pc_mux_sel_i   = sel;
    cycle();
    target_valid_i = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i = 32'h0;
    retire_i = 1'b0;
    target_valid_i = 1'b0;
    pc_mux_sel_i = 2'd0;
    branch_target_i = 32'h0;
    epc_i = 32'h0;
    exc_pc_i = 32'h0;

    // Reset state
    cycle();
    cycle();
    check("rst_req",   {31'd0, instr_req_o},  32'd1);
    check("rst_addr",  instr_addr_o,          32'h0000_0080);
    check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("rst_instr", instr_o,               32'h0000_0013);
    check("rst_pc_o",  pc_o,                  32'h0000_0080);

    // First fetch at boot address
    rst_n = 1'b1;
    instr_gnt_i = 1'b1;
    cycle();
    check("wait_req",  {31'd0, instr_req_o}, 32'd0);
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = 32'h0050_0093;
    cycle();
    instr_rvalid_i = 1'b0;
    check("boot_valid", {31'd0, inst_valid_o}, 32'd1);
    check("boot_instr", instr_o,               32'h0050_0093);
    check("boot_pc_o",  pc_o,                  32'h0000_0080);

    // Multi-cycle hold in VALID
    cycle();
    check("hold_valid", {31'd0, inst_valid_o}, 32'd1);
    check("hold_req",   {31'd0, instr_req_o},  32'd0);

    // Sequential retire
    retire_i = 1'b1;
    cycle();
    retire_i = 1'b0;
    check("ret_valid", {31'd0, inst_valid_o}, 32'd0);
    check("ret_req",   {31'd0, instr_req_o},  32'd1);
    check("ret_addr",  instr_addr_o,          32'h0000_0084);
    fetch(32'h0010_0113);
    check("ret_pc_o",  pc_o,    32'h0000_0084);
    check("ret_instr", instr_o, 32'h0010_0113);

    // Redirect wins over retire; target low bits cleared
    branch_target_i = 32'h0000_0203;
    retire_i = 1'b1;
    redirect(2'd0);
    retire_i = 1'b0;
    check("br_addr",  instr_addr_o,          32'h0000_0200);
    check("br_valid", {31'd0, inst_valid_o}, 32'd0);
    fetch(32'h1111_1111);
    check("br_pc_o", pc_o, 32'h0000_0200);

    // Exception vector, then mret to EPC
    exc_pc_i = 32'h8;
    redirect(2'd2);
    check("exc_addr", instr_addr_o, 32'h0000_0108);
    fetch(32'h2222_2222);
    epc_i = 32'h0000_0084;
    redirect(2'd1);
    check("epc_addr", instr_addr_o, 32'h0000_0084);
    fetch(32'h3333_3333);

    // Unused select encoding falls back to branch target
    branch_target_i = 32'h0000_0301;
    redirect(2'd3);
    check("sel3_addr", instr_addr_o, 32'h0000_0300);
    fetch(32'h4444_4444);
    epc_i = 32'h0000_0084;
    redirect(2'd1);
    fetch(32'h5555_5555);

    // Retire to 0x88, then stall grant with spurious rvalid and stray retire/redirect
    retire_i = 1'b1;
    cycle();
    retire_i = 1'b0;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = 32'hDEAD_BEEF;
    retire_i = 1'b1;
    target_valid_i = 1'b1;
    branch_target_i = 32'h0000_0400;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_addr",  instr_addr_o,          32'h0000_0088);
      check("stall_req",   {31'd0, instr_req_o},  32'd1);
      check("stall_valid", {31'd0, inst_valid_o}, 32'd0);
    end
    instr_rvalid_i = 1'b0;
    retire_i = 1'b0;
    target_valid_i = 1'b0;
    check("stall_instr", instr_o, 32'h5555_5555);
    instr_gnt_i = 1'b1;
    cycle();
    instr_gnt_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("dly_req",   {31'd0, instr_req_o},  32'd0);
      check("dly_valid", {31'd0, inst_valid_o}, 32'd0);
    end
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = 32'h0010_8113;
    cycle();
    instr_rdata_i  = 32'hCAFE_F00D;
    cycle();
    instr_rvalid_i = 1'b0;
    check("dly_instr", instr_o, 32'h0010_8113);
    check("dly_pc_o",  pc_o,    32'h0000_0088);
    check("dly_valid2", {31'd0, inst_valid_o}, 32'd1);

    // PC wrap at top of address space
    branch_target_i = 32'hFFFF_FFFC;
    redirect(2'd0);
    check("top_addr", instr_addr_o, 32'hFFFF_FFFC);
    fetch(32'h6666_6666);
    retire_i = 1'b1;
    cycle();
    retire_i = 1'b0;
    check("wrap_addr", instr_addr_o, 32'h0000_0000);

    // Reset during WAIT_RVALID, late rvalid after release
    instr_gnt_i = 1'b1;
    cycle();
    instr_gnt_i = 1'b0;
    check("pre_rst_req", {31'd0, instr_req_o}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("arst_addr",  instr_addr_o,          32'h0000_0080);
    check("arst_valid", {31'd0, inst_valid_o}, 32'd0);
    cycle();
    rst_n = 1'b1;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = 32'hBAD0_BAD0;
    cycle();
    instr_rvalid_i = 1'b0;
    check("late_valid", {31'd0, inst_valid_o}, 32'd0);
    check("late_instr", instr_o,               32'h0000_0013);
    check("late_req",   {31'd0, instr_req_o},  32'd1);
    check("late_addr",  instr_addr_o,          32'h0000_0080);
    fetch(32'h7777_7777);
    check("refetch_pc_o",  pc_o,    32'h0000_0080);
    check("refetch_instr", instr_o, 32'h7777_7777);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
